// File: rtl/alu_issue_ctrl_if.sv
// Issue handshake and ALU operand/result bus for alu_issue_ctrl.
// master: upstream issuer plus ALU; slave: the issue controller.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 2
);
  // instruction handshake
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [1:0]       in_rd;
  logic [1:0]       in_rs1;
  logic [1:0]       in_rs2;
  // ALU operands
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  // ALU results
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_error;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    output alu_out, alu_zero, alu_carry,
    output alu_overflow, alu_error,
    input  in_ready, alu_a, alu_b, alu_sel
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  alu_out, alu_zero, alu_carry,
    input  alu_overflow, alu_error,
    output in_ready, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for a combinational ALU with a small regfile.
// Ports: clk, rst (async high), bus (issue+ALU), load, status, debug read.
module alu_issue_ctrl #(
  parameter int WIDTH = 2,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  input  logic             i_ld_en,
  input  logic [1:0]       i_ld_addr,
  input  logic [WIDTH-1:0] i_ld_data,
  output logic             o_done,
  output logic             o_done_err,
  output logic [2:0]       o_flags,
  output logic             o_err_sticky,
  input  logic             i_err_clr,
  input  logic [1:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_sel;
  logic [1:0]       r_rd;
  logic [2:0]       r_flags;
  logic             r_done;
  logic             r_done_err;
  logic             r_err_sticky;

  logic             w_idle;
  logic             w_exec;
  logic             w_load;
  logic             w_ready;
  logic             w_accept;
  logic             w_err;

  assign w_idle   = (r_state == S_IDLE);
  assign w_exec   = (r_state == S_EXEC);
  // a direct load claims the IDLE cycle, so issue is stalled
  assign w_load   = w_idle & i_ld_en;
  assign w_ready  = w_idle & ~i_ld_en & ~rst;
  assign w_accept = bus.in_valid & w_ready;
  assign w_err    = w_exec & bus.alu_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // operands are read at accept, so rd==rs sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_rd      <= '0;
    end else if (w_accept) begin
      r_alu_a   <= r_regs[bus.in_rs1];
      r_alu_b   <= r_regs[bus.in_rs2];
      r_alu_sel <= bus.in_op;
      r_rd      <= bus.in_rd;
    end
  end

  // load (IDLE only) and writeback (EXEC end) never coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_load) begin
      r_regs[i_ld_addr] <= i_ld_data;
    end else if (w_exec && !bus.alu_error) begin
      r_regs[r_rd] <= bus.alu_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_exec && !bus.alu_error) begin
      r_flags <= {bus.alu_zero, bus.alu_carry,
                  bus.alu_overflow};
    end
  end

  // done is high exactly during WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_done_err <= 1'b0;
    end else begin
      r_done     <= w_exec;
      r_done_err <= w_err;
    end
  end

  // a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (w_err) begin
      r_err_sticky <= 1'b1;
    end else if (i_err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.alu_sel  = r_alu_sel;

  assign o_done       = r_done;
  assign o_done_err   = r_done_err;
  assign o_flags      = r_flags;
  assign o_err_sticky = r_err_sticky;
  assign o_dbg_data   = r_regs[i_dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 2-bit ALU.
// Vector table for single instructions, hand sequences for corners.
module tb_alu_issue_ctrl;

  localparam int W = 2;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_BAD = 4'b1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld_en;
  logic [1:0]   ld_addr;
  logic [W-1:0] ld_data;
  logic         done;
  logic         done_err;
  logic [2:0]   flags;
  logic         err_sticky;
  logic         err_clr;
  logic [1:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_ctrl_if #(.WIDTH(W)) bus ();

  alu_issue_ctrl #(.WIDTH(W), .NREGS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .i_ld_en      (ld_en),
    .i_ld_addr    (ld_addr),
    .i_ld_data    (ld_data),
    .o_done       (done),
    .o_done_err   (done_err),
    .o_flags      (flags),
    .o_err_sticky (err_sticky),
    .i_err_clr    (err_clr),
    .i_dbg_addr   (dbg_addr),
    .o_dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // reference ALU: carry is carry-out on ADD, borrow on SUB
  logic [W:0]   m_sum;
  logic [W-1:0] m_out;
  always_comb begin
    m_sum            = '0;
    m_out            = '0;
    bus.alu_carry    = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.alu_error    = 1'b0;
    case (bus.alu_sel)
      OP_ADD: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_out = m_sum[W-1:0];
        bus.alu_carry = m_sum[W];
        bus.alu_overflow = (bus.alu_a[W-1] == bus.alu_b[W-1])
                         && (m_out[W-1] != bus.alu_a[W-1]);
      end
      OP_SUB: begin
        m_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        m_out = m_sum[W-1:0];
        bus.alu_carry = m_sum[W];
        bus.alu_overflow = (bus.alu_a[W-1] != bus.alu_b[W-1])
                         && (m_out[W-1] != bus.alu_a[W-1]);
      end
      OP_AND: m_out = bus.alu_a & bus.alu_b;
      OP_OR:  m_out = bus.alu_a | bus.alu_b;
      OP_XOR: m_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_error = 1'b1;
    endcase
    bus.alu_out  = m_out;
    bus.alu_zero = (m_out == '0);
  end

  typedef struct {
    bit         is_ld;
    logic [1:0] addr;
    logic [1:0] data;
    logic [3:0] op;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] exp_val;
    logic [2:0] exp_flags;
    bit         exp_err;
    bit         exp_sticky;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [1:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic load(input logic [1:0] a, input logic [1:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en   = 1'b0;
  endtask

  // returns at the negedge inside WB
  task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input bit clr_exec, output logic derr);
    @(negedge clk);
    chk("done_idle", 8'(done), 8'd0);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    #1;
    chk("ready_idle", 8'(bus.in_ready), 8'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("done_exec", 8'(done), 8'd0);
    chk("ready_exec", 8'(bus.in_ready), 8'd0);
    err_clr = clr_exec;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("done_wb", 8'(done), 8'd1);
    derr = done_err;
  endtask

  initial begin
    logic [1:0] v;
    logic       derr;
    logic [5:0] rdy;
    logic [5:0] dn;
    logic [1:0] r3v [2];
    int         nr3;
    int         npulse;

    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    err_clr      = 1'b0;
    dbg_addr     = '0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;

    vecs.push_back('{1, 2'd0, 2'b01, 4'd0, 2'd0, 2'd0, 2'b01, 3'b000, 0, 0, "ld_r0"});
    vecs.push_back('{1, 2'd1, 2'b01, 4'd0, 2'd0, 2'd0, 2'b01, 3'b000, 0, 0, "ld_r1"});
    vecs.push_back('{0, 2'd2, 2'b00, OP_ADD, 2'd0, 2'd1, 2'b10, 3'b001, 0, 0, "add_ovf"});
    vecs.push_back('{1, 2'd3, 2'b11, 4'd0, 2'd0, 2'd0, 2'b11, 3'b000, 0, 0, "ld_r3"});
    vecs.push_back('{0, 2'd0, 2'b00, OP_ADD, 2'd3, 2'd1, 2'b00, 3'b110, 0, 0, "add_carry"});
    vecs.push_back('{0, 2'd2, 2'b00, OP_BAD, 2'd0, 2'd1, 2'b10, 3'b110, 1, 1, "bad_op"});
    vecs.push_back('{0, 2'd1, 2'b00, OP_XOR, 2'd3, 2'd2, 2'b01, 3'b000, 0, 1, "xor"});
    vecs.push_back('{0, 2'd0, 2'b00, OP_OR, 2'd0, 2'd0, 2'b00, 3'b100, 0, 1, "or_zero"});
    vecs.push_back('{0, 2'd2, 2'b00, OP_SUB, 2'd0, 2'd1, 2'b11, 3'b010, 0, 1, "sub_borrow"});
    vecs.push_back('{0, 2'd1, 2'b00, OP_AND, 2'd2, 2'd3, 2'b11, 3'b000, 0, 1, "and"});

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 8'(bus.in_ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_done_err", 8'(done_err), 8'd0);
    chk("rst_flags", 8'(flags), 8'd0);
    chk("rst_sticky", 8'(err_sticky), 8'd0);
    chk("rst_alu_a", 8'(bus.alu_a), 8'd0);
    chk("rst_alu_b", 8'(bus.alu_b), 8'd0);
    chk("rst_alu_sel", 8'(bus.alu_sel), 8'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      chk("rst_reg", 8'(v), 8'd0);
    end

    foreach (vecs[i]) begin
      if (vecs[i].is_ld) begin
        load(vecs[i].addr, vecs[i].data);
        @(negedge clk);
        rd_reg(vecs[i].addr, v);
        chk({vecs[i].name, "_val"}, 8'(v), 8'(vecs[i].exp_val));
      end else begin
        issue(vecs[i].op, vecs[i].addr, vecs[i].rs1, vecs[i].rs2, 0, derr);
        chk({vecs[i].name, "_err"}, 8'(derr), 8'(vecs[i].exp_err));
        rd_reg(vecs[i].addr, v);
        chk({vecs[i].name, "_val"}, 8'(v), 8'(vecs[i].exp_val));
        chk({vecs[i].name, "_flags"}, 8'(flags), 8'(vecs[i].exp_flags));
        chk({vecs[i].name, "_sticky"}, 8'(err_sticky), 8'(vecs[i].exp_sticky));
      end
    end
    // regs now r0=00 r1=11 r2=11 r3=11

    // sticky clear
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr", 8'(err_sticky), 8'd0);

    // error and clear in the same cycle: error wins
    issue(OP_BAD, 2'd0, 2'd2, 2'd3, 1, derr);
    chk("setwin_err", 8'(derr), 8'd1);
    chk("setwin_sticky", 8'(err_sticky), 8'd1);
    rd_reg(2'd0, v);
    chk("setwin_r0", 8'(v), 8'd0);

    // operands hold after WB
    repeat (3) @(negedge clk);
    chk("hold_sel", 8'(bus.alu_sel), 8'(OP_BAD));
    chk("hold_a", 8'(bus.alu_a), 8'd3);
    chk("hold_b", 8'(bus.alu_b), 8'd3);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;

    // back-to-back SUB with valid held high
    load(2'd1, 2'b01);
    load(2'd3, 2'b11);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_SUB;
    bus.in_rd    = 2'd3;
    bus.in_rs1   = 2'd3;
    bus.in_rs2   = 2'd1;
    nr3 = 0;
    r3v[0] = '0;
    r3v[1] = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      rdy[k] = bus.in_ready;
      dn[k]  = done;
      if (done && nr3 < 2) begin
        dbg_addr = 2'd3;
        #1;
        r3v[nr3] = dbg_data;
        nr3++;
      end
      if (k == 5) bus.in_valid = 1'b0;
      else @(negedge clk);
    end
    chk("b2b_ready", 8'(rdy), 8'b001001);
    chk("b2b_done", 8'(dn), 8'b100100);
    chk("b2b_r3_first", 8'(r3v[0]), 8'b10);
    chk("b2b_r3_second", 8'(r3v[1]), 8'b01);
    chk("b2b_flags", 8'(flags), 8'b001);

    // load and issue together: load first, issue next cycle
    @(negedge clk);
    @(negedge clk);
    ld_en        = 1'b1;
    ld_addr      = 2'd1;
    ld_data      = 2'b10;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_rd    = 2'd2;
    bus.in_rs1   = 2'd1;
    bus.in_rs2   = 2'd0;
    #1;
    chk("ld_pri_ready", 8'(bus.in_ready), 8'd0);
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    @(negedge clk);
    chk("ld_then_ready", 8'(bus.in_ready), 8'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ld_then_a", 8'(bus.alu_a), 8'b10);
    @(negedge clk);
    chk("ld_then_done", 8'(done), 8'd1);
    rd_reg(2'd2, v);
    chk("ld_then_r2", 8'(v), 8'b10);
    rd_reg(2'd1, v);
    chk("ld_then_r1", 8'(v), 8'b10);
    chk("ld_then_flags", 8'(flags), 8'b000);

    // reset during EXEC
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_rd    = 2'd0;
    bus.in_rs1   = 2'd1;
    bus.in_rs2   = 2'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_exec_done", 8'(done), 8'd0);
    chk("rst_exec_flags", 8'(flags), 8'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      chk("rst_exec_reg", 8'(v), 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", 8'(bus.in_ready), 8'd1);
    npulse = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("rst_no_done", 8'(npulse), 8'd0);
    rd_reg(2'd0, v);
    chk("rst_no_wb", 8'(v), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
